// File: rtl/button_debouncer_n.sv
// N-channel button conditioner: 2-flop sync, bounce filter, press/release
// pulses, long-hold detection and optional auto-repeat, all per channel.
module button_debouncer_n #(
  parameter int N             = 5,
  parameter int STABLE_CYCLES = 1000000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int REPEAT_EN     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long_o,
  output logic [N-1:0] repeat_o
);

  localparam int SW   = $clog2(STABLE_CYCLES);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ?
                        LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX) + 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LONG
  } state_t;

  for (genvar k = 0; k < N; k++) begin : g_ch
    logic [1:0]    sync_q;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    state_t        st_q, st_d;
    logic          lvl_q, lvl_d;
    logic          prs_q, prs_d;
    logic          rel_q, rel_d;
    logic          lng_q, lng_d;
    logic          rep_q, rep_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
        scnt_q <= '0;
        hcnt_q <= '0;
        st_q   <= IDLE;
        lvl_q  <= 1'b0;
        prs_q  <= 1'b0;
        rel_q  <= 1'b0;
        lng_q  <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], btn_i[k]};
        scnt_q <= scnt_d;
        hcnt_q <= hcnt_d;
        st_q   <= st_d;
        lvl_q  <= lvl_d;
        prs_q  <= prs_d;
        rel_q  <= rel_d;
        lng_q  <= lng_d;
        rep_q  <= rep_d;
      end
    end

    always_comb begin
      scnt_d = scnt_q;
      hcnt_d = hcnt_q;
      st_d   = st_q;
      lvl_d  = lvl_q;
      prs_d  = 1'b0;
      rel_d  = 1'b0;
      lng_d  = 1'b0;
      rep_d  = 1'b0;

      // any single agreeing cycle restarts the stability window
      if (sync_q[1] == lvl_q) begin
        scnt_d = '0;
      end else if (scnt_q == SW'(STABLE_CYCLES - 1)) begin
        scnt_d = '0;
        lvl_d  = ~lvl_q;
        prs_d  = ~lvl_q;
        rel_d  = lvl_q;
      end else begin
        scnt_d = scnt_q + SW'(1);
      end

      // release takes priority over a coinciding long/repeat
      if (rel_d) begin
        st_d   = IDLE;
        hcnt_d = '0;
      end else begin
        unique case (st_q)
          IDLE: begin
            hcnt_d = '0;
            if (prs_d) st_d = HOLD;
          end
          HOLD: begin
            if (hcnt_q == HW'(LONG_CYCLES - 1)) begin
              lng_d  = 1'b1;
              hcnt_d = '0;
              st_d   = LONG;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
          LONG: begin
            if (REPEAT_EN == 0) begin
              hcnt_d = '0;
            end else if (hcnt_q == HW'(REPEAT_CYCLES - 1)) begin
              rep_d  = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
          default: begin
            st_d   = IDLE;
            hcnt_d = '0;
          end
        endcase
      end
    end

    assign level_o[k]   = lvl_q;
    assign press_o[k]   = prs_q;
    assign release_o[k] = rel_q;
    assign long_o[k]    = lng_q;
    assign repeat_o[k]  = rep_q;
  end

endmodule

// File: tb/tb_button_debouncer_n.sv
// Bench for button_debouncer_n: directed scenarios plus random stimulus,
// checked every cycle against a history-window reference model.
module tb_button_debouncer_n;

  localparam int N = 3;
  localparam int S = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;

  logic [N-1:0] lvl1, prs1, rel1, lng1, rep1;
  logic [N-1:0] lvl0, prs0, rel0, lng0, rep0;

  always #5 clk = ~clk;

  button_debouncer_n #(
    .N(N), .STABLE_CYCLES(S), .LONG_CYCLES(L),
    .REPEAT_CYCLES(R), .REPEAT_EN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn),
    .level_o(lvl1), .press_o(prs1), .release_o(rel1),
    .long_o(lng1), .repeat_o(rep1)
  );

  button_debouncer_n #(
    .N(N), .STABLE_CYCLES(S), .LONG_CYCLES(L),
    .REPEAT_CYCLES(R), .REPEAT_EN(0)
  ) dut_norep (
    .clk_i(clk), .rst_i(rst), .btn_i(btn),
    .level_o(lvl0), .press_o(prs0), .release_o(rel0),
    .long_o(lng0), .repeat_o(rep0)
  );

  int nerr = 0;
  int nchk = 0;

  // h[i] = btn sampled i+1 edges ago
  logic [N-1:0] h [0:7];
  logic [N-1:0] m_lvl, m_prs, m_rel, m_lng, m_rep;
  int           pe [N];
  bit           held [N];
  int           cyc = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) h[i] = '0;
    m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_rep = '0;
    for (int c = 0; c < N; c++) begin
      held[c] = 1'b0;
      pe[c]   = 0;
    end
  endtask

  // a level flips once the synchronised input has disagreed for S edges;
  // long/repeat follow from the number of edges since the press
  task automatic model_edge();
    bit tg;
    int t;
    for (int c = 0; c < N; c++) begin
      tg = 1'b1;
      for (int j = 0; j < S; j++)
        if (h[1+j][c] == m_lvl[c]) tg = 1'b0;
      m_prs[c] = tg && !m_lvl[c];
      m_rel[c] = tg && m_lvl[c];
      if (tg) begin
        m_lvl[c] = ~m_lvl[c];
        held[c]  = m_lvl[c];
        pe[c]    = cyc;
      end
      t = cyc - pe[c];
      m_lng[c] = held[c] && (t == L);
      m_rep[c] = held[c] && (t > L) && ((t - L) % R == 0);
    end
    for (int i = 7; i > 0; i--) h[i] = h[i-1];
    h[0] = btn;
    cyc++;
  endtask

  task automatic check_all();
    chk("level",      lvl1, m_lvl);
    chk("press",      prs1, m_prs);
    chk("release",    rel1, m_rel);
    chk("long",       lng1, m_lng);
    chk("repeat",     rep1, m_rep);
    chk("nr_level",   lvl0, m_lvl);
    chk("nr_press",   prs0, m_prs);
    chk("nr_release", rel0, m_rel);
    chk("nr_long",    lng0, m_lng);
    chk("nr_repeat",  rep0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // edges until press on channel c, -1 if it never comes
  task automatic wait_press(input int c, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (prs1[c]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, long_at, reps, reps0, long0_at, rel_at, lngs;

    rst = 1'b1;
    btn = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    ticks(3);

    // clean press on ch0
    btn = 3'b001;
    wait_press(0, n);
    chk_int("press_latency_ch0", n, 6);
    tick();
    btn = 3'b000;
    ticks(10);

    // bounce on ch1
    btn = 3'b010;
    ticks(3);
    btn = 3'b000;
    tick();
    btn = 3'b010;
    n = 0;
    reps = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (prs1[1]) begin
        reps++;
        if (n == 0) n = i;
      end
    end
    chk_int("bounce_press_edge", n, 6);
    chk_int("bounce_press_count", reps, 1);
    btn = 3'b000;
    ticks(10);

    // long hold with repeat on ch2
    btn = 3'b100;
    wait_press(2, n);
    chk_int("press_latency_ch2", n, 6);
    long_at = -1; long0_at = -1; reps = 0; reps0 = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (lng1[2]) long_at = k;
      if (lng0[2]) long0_at = k;
      if (rep1[2]) reps++;
      if (rep0[2]) reps0++;
    end
    chk_int("long_edge", long_at, 20);
    chk_int("nr_long_edge", long0_at, 20);
    chk_int("repeat_count", reps, 8);
    chk_int("nr_repeat_count", reps0, 0);
    btn = 3'b000;
    rel_at = -1;
    reps = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rel1[2]) rel_at = k;
      if (rel_at > 0 && rep1[2]) reps++;
    end
    chk_int("release_edge_ch2", rel_at, 6);
    chk_int("repeat_after_release", reps, 0);

    // release landing exactly on the long boundary
    btn = 3'b001;
    wait_press(0, n);
    ticks(14);
    btn = 3'b000;
    rel_at = -1;
    lngs = 0;
    for (int k = 15; k <= 30; k++) begin
      tick();
      if (rel1[0]) rel_at = k;
      if (lng1[0]) lngs++;
    end
    chk_int("boundary_release_edge", rel_at, 20);
    chk_int("boundary_long_count", lngs, 0);

    // async reset while in LONG
    btn = 3'b001;
    wait_press(0, n);
    ticks(25);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
    wait_press(0, n);
    chk_int("press_after_reset", n, 6);
    btn = 3'b000;
    ticks(10);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 13) == 0) btn[c] = ~btn[c];
      tick();
    end
    btn = '0;
    ticks(10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/button_debouncer_n.md
Name: button_debouncer_n

Overview:
- Parametrised N-channel successor to the fixed five-button debouncer.
- Per channel:
  - synchronises the raw pin and filters bounce;
  - emits a clean level plus one-cycle press and release pulses;
  - detects long holds and, optionally, generates auto-repeat pulses.
- Sits between the board button/switch pins and the state logic on the 100 MHz domain.

Parameters:
- N, 5, number of independent channels.
- STABLE_CYCLES, 1000000, consecutive mismatch cycles needed to accept a new level (10 ms at 100 MHz); minimum 2.
- LONG_CYCLES, 50000000, hold cycles after press before long_o fires; minimum 2.
- REPEAT_CYCLES, 10000000, period of repeat_o while held after long_o; minimum 2.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 ties repeat_o to 0.

Ports:
- clk_i  input  1  system clock (100 MHz).
- rst_i  input  1  reset; asynchronous, active-high.
- btn_i  input  N  raw asynchronous button inputs, bit k = channel k.
- level_o  output  N  debounced level.
- press_o  output  N  one-cycle pulse on debounced rising edge.
- release_o  output  N  one-cycle pulse on debounced falling edge.
- long_o  output  N  one-cycle pulse when a hold reaches LONG_CYCLES.
- repeat_o  output  N  one-cycle auto-repeat pulses after long_o.

Behaviour:
- Fixed decision: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset:
  - all outputs, synchroniser flops, stability counters and hold counters clear to 0;
  - reset mid-press drops level_o to 0 with no release_o pulse.
- Channels are fully independent; same logic replicated by generate loop.
- Synchroniser: 2 flops per channel. sync_k = btn_i[k] delayed 2 edges.
- Stability counter:
  - width $clog2(STABLE_CYCLES).
  - Each edge: if sync_k == level_o[k], counter <= 0.
  - Otherwise, if counter == STABLE_CYCLES-1: level_o[k] toggles and counter <= 0.
  - Otherwise counter increments.
  - Any single-cycle agreement restarts the count (bounce rejection).
- Latency: a clean input step appears on level_o exactly 2 + STABLE_CYCLES edges after the btn_i change.
- press_o / release_o:
  - registered on the same edge that toggles level_o (press_o when the toggle is 0→1, release_o when 1→0);
  - high for exactly one cycle.
- Hold counter:
  - width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)) + 1.
  - Cleared to 0 on the press edge and whenever level_o is 0.
  - While level_o is 1, increments each edge in state HOLD.
- Per-channel FSM states: IDLE, HOLD, LONG.
  - IDLE:
    - on press → HOLD, counter = 0.
  - HOLD:
    - counter == LONG_CYCLES-1 → long_o pulse, counter = 0, go to LONG.
    - long_o therefore fires LONG_CYCLES edges after press_o.
  - LONG:
    - with REPEAT_EN=1: counter == REPEAT_CYCLES-1 → repeat_o pulse, counter = 0, stay in LONG. The first repeat comes REPEAT_CYCLES edges after long_o; pulses continue periodically.
    - with REPEAT_EN=0: counter holds at 0; no pulses.
  - Release from any state → IDLE, counter cleared, no long/repeat on that edge.
- Simultaneous events:
  - release on the same edge long_o or repeat_o would fire: release wins and the long/repeat pulse is suppressed;
  - press_o and long_o never coincide, since LONG_CYCLES ≥ 2.
- No counter wraps: each counter is cleared on its terminal value or held.

Test Plan:
Bench parameters: N=3, STABLE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, REPEAT_EN=1. Edge 0 = the edge at which btn_i changes.
- Clean press on ch0 (btn_i=3'b001 held) → level_o[0]=1 and press_o[0]=1 at edge 6, press_o[0]=0 at edge 7. Channels 1 and 2 stay 0.
- Bounce on ch1:
  - stimulus: 3-cycle high glitch, 1 low cycle, then stable high;
  - → no output during the glitch;
  - → level_o[1] rises 6 edges after the final rising transition;
  - → exactly one press_o[1] pulse.
- Long hold with repeat on ch2:
  - stimulus: held 60 cycles after press_o[2];
  - → long_o[2] at press+20;
  - → repeat_o[2] at press+25, +30, +35, ...;
  - → release_o[2] at 6 edges after btn_i falls, and no further repeats after it.
- Release on long boundary on ch0:
  - stimulus: btn_i falls so that level_o falls exactly at press+20;
  - → release_o[0]=1 on that edge;
  - → long_o[0] stays 0 throughout.
- Async reset mid-hold:
  - stimulus: rst_i pulsed between clock edges while ch0 is in LONG;
  - → all outputs read 0 immediately, with no release_o;
  - → after rst_i deasserts with btn_i still high, a fresh press_o at 6 edges.
- REPEAT_EN=0 rerun of the long-hold scenario → long_o[2] at press+20, repeat_o stays 0 for the full hold.
